// File: rtl/sr_latch_pkg.sv
// sr_latch_pkg: command encoding and reset values shared by the latch bank
package sr_latch_pkg;
  typedef enum logic [1:0] {
    CMD_HOLD   = 2'b00,
    CMD_RESET  = 2'b01,
    CMD_SET    = 2'b10,
    CMD_FORBID = 2'b11
  } sr_cmd_t;
  localparam logic Q_RST  = 1'b0;
  localparam logic QB_RST = 1'b1;
endpackage

// File: rtl/sr_latch_if.sv
// sr_latch_if: active-low set/reset inputs and latch outputs of a WIDTH-bit bank
interface sr_latch_if #(parameter int WIDTH = 1);
  logic [WIDTH-1:0] s0;
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] r0;
  logic [WIDTH-1:0] r1;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic [WIDTH-1:0] illegal;
  logic [WIDTH-1:0] race_err;
  modport master (output s0, s1, r0, r1, input q, q_bar, illegal, race_err);
  modport slave (input s0, s1, r0, r1, output q, q_bar, illegal, race_err);
endinterface

// File: rtl/sr_latch_cell.sv
// sr_latch_cell: one NAND-style SR latch bit with registered command and race tracking
module sr_latch_cell
  import sr_latch_pkg::*;
#(
  parameter bit RACE_RESOLVE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_s0,
  input  logic i_s1,
  input  logic i_r0,
  input  logic i_r1,
  output logic o_q,
  output logic o_q_bar,
  output logic o_illegal,
  output logic o_race_err
);
  sr_cmd_t w_cmd;
  logic    w_race;
  logic    r_q;
  logic    r_q_bar;
  logic    r_forbid;
  logic    r_race;
  assign w_cmd  = sr_cmd_t'({~(i_s0 & i_s1), ~(i_r0 & i_r1)});
  // leaving FORBID straight into HOLD is the metastable race; resolve it deterministically
  assign w_race = r_forbid && (w_cmd == CMD_HOLD);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q      <= Q_RST;
      r_q_bar  <= QB_RST;
      r_forbid <= 1'b0;
      r_race   <= 1'b0;
    end else begin
      r_q      <= w_race ? RACE_RESOLVE : (w_cmd == CMD_HOLD) ? r_q : (w_cmd != CMD_RESET);
      r_q_bar  <= w_race ? ~RACE_RESOLVE : (w_cmd == CMD_HOLD) ? r_q_bar : (w_cmd != CMD_SET);
      r_forbid <= (w_cmd == CMD_FORBID);
      r_race   <= r_race | w_race;
    end
  end
  assign o_q        = r_q;
  assign o_q_bar    = r_q_bar;
  assign o_illegal  = r_forbid;
  assign o_race_err = r_race;
endmodule

// File: rtl/sr_latch.sv
// sr_latch: bank of WIDTH independent clocked NAND-style SR latch bits
module sr_latch
  import sr_latch_pkg::*;
#(
  parameter int WIDTH        = 1,
  parameter bit RACE_RESOLVE = 1'b0
) (
  input logic        clk,
  input logic        rst_n,
  sr_latch_if.slave  bus
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sr_latch_cell #(.RACE_RESOLVE(RACE_RESOLVE)) u_cell (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_s0       (bus.s0[i]),
      .i_s1       (bus.s1[i]),
      .i_r0       (bus.r0[i]),
      .i_r1       (bus.r1[i]),
      .o_q        (bus.q[i]),
      .o_q_bar    (bus.q_bar[i]),
      .o_illegal  (bus.illegal[i]),
      .o_race_err (bus.race_err[i])
    );
  end
endmodule

// File: tb/tb_sr_latch.sv
// tb_sr_latch: directed scoreboard bench for a 1-bit (RACE_RESOLVE=0) and a 4-bit (RACE_RESOLVE=1) latch bank
module tb_sr_latch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  typedef struct {
    string      tag;
    bit         wide;
    logic [3:0] q;
    logic [3:0] qb;
    logic [3:0] ill;
    logic [3:0] race;
  } exp_t;
  exp_t sbq[$];
  logic m_q, m_qb, m_ill, m_race, m_prev;
  sr_latch_if #(.WIDTH(1)) if1 ();
  sr_latch_if #(.WIDTH(4)) if4 ();
  sr_latch #(.WIDTH(1), .RACE_RESOLVE(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  sr_latch #(.WIDTH(4), .RACE_RESOLVE(1'b1)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  always #5 clk = ~clk;
  task automatic cmp(string tag, logic [3:0] got, logic [3:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_q = 1'b0; m_qb = 1'b1; m_ill = 1'b0; m_race = 1'b0; m_prev = 1'b0;
  endtask
  task automatic drive1(logic [3:0] v, string tag);
    logic set_a, rst_a;
    exp_t e;
    @(negedge clk);
    {if1.s0, if1.s1, if1.r0, if1.r1} = v;
    set_a = !(v[3] && v[2]);
    rst_a = !(v[1] && v[0]);
    if (set_a && rst_a) begin m_q = 1'b1; m_qb = 1'b1; end
    else if (set_a) begin m_q = 1'b1; m_qb = 1'b0; end
    else if (rst_a) begin m_q = 1'b0; m_qb = 1'b1; end
    else if (m_prev) begin m_q = 1'b0; m_qb = 1'b1; m_race = 1'b1; end
    m_ill = set_a && rst_a;
    m_prev = m_ill;
    e.tag = tag; e.wide = 1'b0;
    e.q = {3'b0, m_q}; e.qb = {3'b0, m_qb}; e.ill = {3'b0, m_ill}; e.race = {3'b0, m_race};
    sbq.push_back(e);
  endtask
  task automatic drive4(logic [3:0] s0, logic [3:0] s1, logic [3:0] r0, logic [3:0] r1,
                        logic [3:0] q, logic [3:0] qb, logic [3:0] ill, logic [3:0] race, string tag);
    exp_t e;
    @(negedge clk);
    if4.s0 = s0; if4.s1 = s1; if4.r0 = r0; if4.r1 = r1;
    e.tag = tag; e.wide = 1'b1; e.q = q; e.qb = qb; e.ill = ill; e.race = race;
    sbq.push_back(e);
  endtask
  task automatic check();
    exp_t e;
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty got=0 entries exp=1");
    end else begin
      e = sbq.pop_front();
      if (e.wide) begin
        cmp({e.tag, ".q"}, if4.q, e.q);
        cmp({e.tag, ".q_bar"}, if4.q_bar, e.qb);
        cmp({e.tag, ".illegal"}, if4.illegal, e.ill);
        cmp({e.tag, ".race_err"}, if4.race_err, e.race);
      end else begin
        cmp({e.tag, ".q"}, {3'b0, if1.q}, e.q);
        cmp({e.tag, ".q_bar"}, {3'b0, if1.q_bar}, e.qb);
        cmp({e.tag, ".illegal"}, {3'b0, if1.illegal}, e.ill);
        cmp({e.tag, ".race_err"}, {3'b0, if1.race_err}, e.race);
      end
    end
  endtask
  task automatic step1(logic [3:0] v, string tag);
    drive1(v, tag);
    check();
  endtask
  task automatic async_reset(string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    cmp({tag, ".q1"}, {3'b0, if1.q}, 4'b0000);
    cmp({tag, ".qb1"}, {3'b0, if1.q_bar}, 4'b0001);
    cmp({tag, ".ill1"}, {3'b0, if1.illegal}, 4'b0000);
    cmp({tag, ".race1"}, {3'b0, if1.race_err}, 4'b0000);
    cmp({tag, ".q4"}, if4.q, 4'b0000);
    cmp({tag, ".qb4"}, if4.q_bar, 4'b1111);
    cmp({tag, ".race4"}, if4.race_err, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    {if1.s0, if1.s1, if1.r0, if1.r1} = 4'b1111;
    {if4.s0, if4.s1, if4.r0, if4.r1} = {4'hF, 4'hF, 4'hF, 4'hF};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cmp("por.q", {3'b0, if1.q}, 4'b0000);
    cmp("por.q_bar", {3'b0, if1.q_bar}, 4'b0001);
    @(negedge clk);
    rst_n = 1'b1;
    for (int v = 0; v < 16; v++) step1(4'(v), $sformatf("sweep%0d", v));
    step1(4'b0000, "race_forbid");
    step1(4'b1111, "race_hold");
    step1(4'b0011, "race_sticky_set");
    step1(4'b1100, "race_sticky_reset");
    step1(4'b0011, "preset_q1");
    async_reset("areset");
    step1(4'b0000, "f2s_forbid");
    step1(4'b0111, "f2s_set");
    step1(4'b0011, "hs_set");
    for (int k = 0; k < 3; k++) step1(4'b1111, $sformatf("hs_hold%0d", k));
    step1(4'b1100, "hr_reset");
    for (int k = 0; k < 3; k++) step1(4'b1111, $sformatf("hr_hold%0d", k));
    drive4(4'b1101, 4'hF, 4'hF, 4'hF, 4'b0010, 4'b1101, 4'b0000, 4'b0000, "w4_pre");
    check();
    drive4(4'b1010, 4'hF, 4'b1001, 4'hF, 4'b0101, 4'b1110, 4'b0100, 4'b0000, "w4_mixed");
    check();
    drive4(4'hF, 4'hF, 4'hF, 4'hF, 4'b0101, 4'b1010, 4'b0000, 4'b0100, "w4_race");
    check();
    drive4(4'hF, 4'hF, 4'hF, 4'b1011, 4'b0001, 4'b1110, 4'b0000, 4'b0100, "w4_sticky");
    check();
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_leftover got=%0d exp=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
